cordic_postproc: RTL and testbench

Output stage of the CORDIC unit: consumes one `cordic_reg` per handshake from the last CORDIC iteration stage, selects the result coordinate, and packs it into the 18-bit float format used on the GPU result bus. It handles sign, leading-one normalisation, round-to-nearest-even, overflow, underflow and special-case override. It is a 2-stage valid/ready pipeline between the CORDIC array and the writeback arbiter.

---
 rtl/cordic_pkg.sv | 52 +++++
 rtl/cordic_postproc_lod17.sv | 23 ++
 rtl/cordic_postproc.sv | 141 ++++++++++++++
 tb/tb_cordic_postproc.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC types: final-stage register, function code, and the 18-bit
// result-bus float format with the post-processing pipeline register.
package cordic_pkg;

    typedef logic [4:0] func5_t;

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } cordic_mode_e;

    // Contents of the last CORDIC iteration stage; coordinates are s12.4.
    typedef struct packed {
        logic         valid;
        func5_t       func;
        cordic_mode_e mode;
        logic [16:0]  x;
        logic [16:0]  y;
        logic [16:0]  z;
        logic [6:0]   fp_exponent;
        logic         fp_sign;
        logic         override;
        logic [17:0]  override_val;
    } cordic_reg;

    typedef struct packed {
        logic       sign;
        logic [6:0] exp;
        logic [9:0] mant;
    } fp18_t;

    localparam logic [6:0] FP_BIAS    = 7'd63;
    localparam logic [6:0] FP_EXP_INF = 7'h7F;

    typedef struct packed {
        logic               valid;
        func5_t             func;
        logic               sign;
        logic               zero;
        logic [16:0]        mag;
        logic [4:0]         lop;
        logic signed [8:0]  exp;
        logic               override;
        logic [17:0]        override_val;
    } cordic_post_s1;

    function automatic logic [16:0] abs17(input logic [16:0] v);
        // -4096.0 wraps to 0x10000, which is the correct unsigned magnitude.
        return v[16] ? (17'd0 - v) : v;
    endfunction

endpackage

// File: rtl/cordic_postproc_lod17.sv
// Leading-one detector for a 17-bit magnitude: bit index of the MSB set,
// plus a flag for an all-zero input.
module lod17 (
    input  logic [16:0] i_val,
    output logic [4:0]  o_pos,
    output logic        o_zero
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        o_pos = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (i_val[i]) begin
                o_pos = 5'(i);
            end else begin
                o_pos = o_pos;
            end
        end
    end

    assign o_zero = ~|i_val;

endmodule

// File: rtl/cordic_postproc.sv
// CORDIC output stage: selects the result coordinate and packs it into the
// 18-bit result-bus float through a two-stage valid/ready pipeline.
module cordic_postproc
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  cordic_reg   in_reg,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_data,
    output func5_t      out_func
);

    logic          w_adv1;
    logic          w_adv2;
    logic [16:0]   w_sel;
    logic [16:0]   w_mag;
    logic [4:0]    w_lop;
    logic          w_zero;
    cordic_post_s1 w_s1_next;
    cordic_post_s1 r_s1;

    logic              r_out_valid;
    logic [17:0]       r_out_data;
    func5_t            r_out_func;

    logic [4:0]        w_shamt;
    logic [16:0]       w_norm;
    logic [9:0]        w_mant_t;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [10:0]       w_mant_sum;
    logic [9:0]        w_mant;
    logic signed [8:0] w_exp_r;
    fp18_t             w_pack;

    logic [16:0]       w_unused_x;
    logic              w_unused_lead;

    assign w_unused_x    = in_reg.x;
    assign w_unused_lead = w_norm[16];

    // in_ready depends only on pipeline occupancy and out_ready.
    assign w_adv2    = !r_out_valid || out_ready;
    assign w_adv1    = !r_s1.valid || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_func  = r_out_func;

    // Result coordinate select.
    always_comb begin
        if (in_reg.mode == VECTORING) begin
            w_sel = in_reg.z;
        end else begin
            w_sel = in_reg.y;
        end
    end

    assign w_mag = abs17(w_sel);

    lod17 u_lod17 (
        .i_val  (w_mag),
        .o_pos  (w_lop),
        .o_zero (w_zero)
    );

    // S1 next-state: sign, magnitude, leading-one position, pre-round exponent.
    always_comb begin
        w_s1_next              = '0;
        w_s1_next.valid        = in_reg.valid;
        w_s1_next.func         = in_reg.func;
        w_s1_next.sign         = w_sel[16] ^ in_reg.fp_sign;
        w_s1_next.zero         = w_zero;
        w_s1_next.mag          = w_mag;
        w_s1_next.lop          = w_lop;
        w_s1_next.exp          = $signed({2'b00, in_reg.fp_exponent})
                               + $signed({4'b0000, w_lop}) - 9'sd4;
        w_s1_next.override     = in_reg.override;
        w_s1_next.override_val = in_reg.override_val;
    end

    // S1 register; holds while S2 is stalled and full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (w_adv1) begin
            r_s1 <= w_s1_next;
        end
    end

    // Normalise so the leading one sits at bit 16; small values get zero fill
    // below, which also forces guard and sticky to zero.
    assign w_shamt    = 5'd16 - r_s1.lop;
    assign w_norm     = r_s1.mag << w_shamt;
    assign w_mant_t   = w_norm[15:6];
    assign w_guard    = w_norm[5];
    assign w_sticky   = |w_norm[4:0];
    assign w_round_up = w_guard & (w_sticky | w_mant_t[0]);
    assign w_mant_sum = {1'b0, w_mant_t} + {10'd0, w_round_up};
    assign w_mant     = w_mant_sum[9:0];
    assign w_exp_r    = r_s1.exp + $signed({8'd0, w_mant_sum[10]});

    // Special-case priority: override, zero, overflow, underflow, normal.
    always_comb begin
        w_pack = '0;
        if (r_s1.override) begin
            w_pack = fp18_t'(r_s1.override_val);
        end else if (r_s1.zero) begin
            w_pack.sign = r_s1.sign;
        end else if (w_exp_r >= 9'sd127) begin
            w_pack.sign = r_s1.sign;
            w_pack.exp  = FP_EXP_INF;
        end else if (w_exp_r <= 9'sd0) begin
            w_pack.sign = r_s1.sign;
        end else begin
            w_pack.sign = r_s1.sign;
            w_pack.exp  = w_exp_r[6:0];
            w_pack.mant = w_mant;
        end
    end

    // S2 output register; data only moves when a valid result advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 18'd0;
            r_out_func  <= 5'd0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_out_data <= w_pack;
                r_out_func <= r_s1.func;
            end
        end
    end

endmodule

// File: tb/tb_cordic_postproc.sv
// Directed bench for cordic_postproc: hand-computed float packing vectors,
// backpressure ordering and mid-operation reset.
module tb_cordic_postproc;
    import cordic_pkg::*;

    logic        clk;
    logic        rst;
    cordic_reg   in_reg;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    func5_t      out_func;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] bp_y   [4] = '{17'h00010, 17'h1FFE8, 17'h00020, 17'h00018};
    logic [17:0] bp_exp [4] = '{18'h0FC00, 18'h2FE00, 18'h10000, 18'h0FE00};
    func5_t      bp_f   [4] = '{5'd21, 5'd22, 5'd23, 5'd24};

    cordic_postproc dut (
        .clk       (clk),
        .rst       (rst),
        .in_reg    (in_reg),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_func  (out_func)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input cordic_mode_e mode, input logic [16:0] y,
                          input logic [16:0] z, input logic [6:0] fpe, input logic fps,
                          input logic ovr, input logic [17:0] ovv, input func5_t f);
        in_reg.valid        = v;
        in_reg.func         = f;
        in_reg.mode         = mode;
        in_reg.x            = 17'h0AAAA;
        in_reg.y            = y;
        in_reg.z            = z;
        in_reg.fp_exponent  = fpe;
        in_reg.fp_sign      = fps;
        in_reg.override     = ovr;
        in_reg.override_val = ovv;
    endtask

    // Called at posedge+1 with an empty pipe and out_ready high.
    task automatic run_one(input string tag, input cordic_mode_e mode, input logic [16:0] y,
                           input logic [16:0] z, input logic [6:0] fpe, input logic fps,
                           input logic ovr, input logic [17:0] ovv, input func5_t f,
                           input logic [17:0] exp);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        set_in(1'b1, mode, y, z, fpe, fps, ovr, ovv, f);
        @(posedge clk); #1;
        in_reg.valid = 1'b0;
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp));
        chk({tag, "_fn"}, 32'(out_func), 32'(f));
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int got;

        rst       = 1'b1;
        out_ready = 1'b1;
        in_reg    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_func",  32'(out_func),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);

        run_one("pos",      ROTATION,  17'h00010, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd1,  18'h0FC00);
        run_one("neg",      ROTATION,  17'h1FFE8, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd2,  18'h2FE00);
        run_one("neg_fs",   ROTATION,  17'h1FFE8, 17'h0,     7'd63,  1'b1, 1'b0, 18'h0, 5'd3,  18'h0FE00);
        run_one("carry",    ROTATION,  17'h0FFFF, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd4,  18'h12C00);
        run_one("ovf",      ROTATION,  17'h0FFFF, 17'h0,     7'd120, 1'b0, 1'b0, 18'h0, 5'd5,  18'h1FC00);
        run_one("unf",      ROTATION,  17'h00001, 17'h0,     7'd2,   1'b0, 1'b0, 18'h0, 5'd6,  18'h00000);
        run_one("zero",     ROTATION,  17'h00000, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd7,  18'h00000);
        run_one("ovr",      ROTATION,  17'h0FFFF, 17'h01234, 7'd63,  1'b0, 1'b1, 18'h3FFFF, 5'd8, 18'h3FFFF);
        run_one("vec",      VECTORING, 17'h00020, 17'h00010, 7'd63,  1'b0, 1'b0, 18'h0, 5'd9,  18'h0FC00);
        run_one("tie_even", ROTATION,  17'h00801, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd10, 18'h11800);
        run_one("tie_odd",  ROTATION,  17'h00803, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd11, 18'h11802);
        run_one("min_neg",  ROTATION,  17'h10000, 17'h0,     7'd63,  1'b0, 1'b0, 18'h0, 5'd12, 18'h32C00);
        run_one("emin",     ROTATION,  17'h00001, 17'h0,     7'd5,   1'b0, 1'b0, 18'h0, 5'd13, 18'h00400);
        run_one("emin_m1",  ROTATION,  17'h00001, 17'h0,     7'd4,   1'b0, 1'b0, 18'h0, 5'd14, 18'h00000);
        run_one("emax",     ROTATION,  17'h00010, 17'h0,     7'd126, 1'b0, 1'b0, 18'h0, 5'd15, 18'h1F800);
        run_one("einf",     ROTATION,  17'h00010, 17'h0,     7'd127, 1'b0, 1'b0, 18'h0, 5'd16, 18'h1FC00);

        // Backpressure: out_ready low for the first 5 cycles, then released.
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            if (acc < 4) begin
                set_in(1'b1, ROTATION, bp_y[acc], 17'h0, 7'd63, 1'b0, 1'b0, 18'h0, bp_f[acc]);
            end else begin
                in_reg.valid = 1'b0;
            end
            #1;
            if (cyc == 3) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_accepts", 32'(acc), 32'd2);
            end
            if (cyc >= 2 && cyc < 5) begin
                chk("bp_stall_valid", 32'(out_valid), 32'd1);
                chk("bp_stall_data", 32'(out_data), 32'(bp_exp[0]));
            end
            if (out_valid && out_ready) begin
                chk("bp_data", 32'(out_data), 32'(bp_exp[got]));
                chk("bp_func", 32'(out_func), 32'(bp_f[got]));
                got++;
            end
            if (in_reg.valid && in_ready) begin
                acc++;
            end
            @(posedge clk); #1;
        end
        in_reg.valid = 1'b0;
        chk("bp_count", 32'(got), 32'd4);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with both stages full.
        out_ready = 1'b0;
        set_in(1'b1, ROTATION, 17'h00010, 17'h0, 7'd63, 1'b0, 1'b0, 18'h0, 5'd30);
        @(posedge clk); #1;
        set_in(1'b1, ROTATION, 17'h00020, 17'h0, 7'd63, 1'b0, 1'b0, 18'h0, 5'd31);
        @(posedge clk); #1;
        in_reg.valid = 1'b0;
        chk("mid_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_func",  32'(out_func),  32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
